capture_sequencer: RTL and testbench

Sequences one acquisition from arm to completion. It sits between the channel mapper's 256-bit word stream and the sample buffer write port. It owns the ring-buffer write address, pre-trigger fill and trigger acceptance, post-trigger countdown, and done status. Software reads `trig_addr`/`trig_sample` afterwards to locate the trigger in the buffer.

---
 rtl/capture_pkg.sv | 21 ++
 rtl/capture_sequencer.sv | 151 +++++++++++++++
 tb/tb_capture_sequencer.sv | 395 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/capture_pkg.sv
// Shared types and widths for the capture sequencer: FSM state encoding,
// data/trigger widths and a small state-classification helper.
package capture_pkg;

    localparam int CAP_DATA_W = 256;
    localparam int CAP_TRIG_W = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRE       = 3'd1,
        WAIT_TRIG = 3'd2,
        POST      = 3'd3,
        DONE      = 3'd4
    } capture_state_t;

    // States in which incoming words are written to the buffer.
    function automatic logic is_capturing(input capture_state_t s);
        return (s == PRE) || (s == WAIT_TRIG) || (s == POST);
    endfunction

endpackage

// File: rtl/capture_sequencer.sv
// Sequences one acquisition: ring-buffer write addressing, pre-trigger fill,
// trigger acceptance, post-trigger countdown and done status.
module capture_sequencer
    import capture_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  arm,
    input  logic                  abort,
    input  logic [ADDR_W-1:0]     pre_words,
    input  logic [ADDR_W-1:0]     post_words,
    input  logic                  in_valid,
    input  logic [CAP_DATA_W-1:0] in_data,
    input  logic                  in_triggered,
    input  logic [CAP_TRIG_W-1:0] in_trig_sample,
    output logic                  wr_en,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic [CAP_DATA_W-1:0] wr_data,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_W-1:0]     trig_addr,
    output logic [CAP_TRIG_W-1:0] trig_sample
);

    capture_state_t state, state_nxt;

    logic [ADDR_W-1:0]     ptr, ptr_nxt;
    logic [ADDR_W-1:0]     pre_cnt, pre_cnt_nxt, pre_cnt_inc;
    logic [ADDR_W-1:0]     post_cnt, post_cnt_nxt;
    logic [ADDR_W-1:0]     pre_words_q, pre_words_nxt;
    logic [ADDR_W-1:0]     post_words_q, post_words_nxt;
    logic [ADDR_W-1:0]     trig_addr_nxt;
    logic [CAP_TRIG_W-1:0] trig_sample_nxt;
    logic                  wr_en_nxt;
    logic [ADDR_W-1:0]     wr_addr_nxt;
    logic [CAP_DATA_W-1:0] wr_data_nxt;
    logic                  take_word;

    assign pre_cnt_inc = pre_cnt + ADDR_W'(1);

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        state_nxt       = state;
        ptr_nxt         = ptr;
        pre_cnt_nxt     = pre_cnt;
        post_cnt_nxt    = post_cnt;
        pre_words_nxt   = pre_words_q;
        post_words_nxt  = post_words_q;
        trig_addr_nxt   = trig_addr;
        trig_sample_nxt = trig_sample;
        wr_en_nxt       = 1'b0;
        wr_addr_nxt     = wr_addr;
        wr_data_nxt     = wr_data;
        take_word       = 1'b0;

        if (abort) begin
            // Abort dominates a simultaneous arm and suppresses this cycle's word.
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (arm) begin
                        ptr_nxt         = '0;
                        pre_cnt_nxt     = '0;
                        pre_words_nxt   = pre_words;
                        post_words_nxt  = post_words;
                        trig_addr_nxt   = '0;
                        trig_sample_nxt = '0;
                        state_nxt       = (pre_words == '0) ? WAIT_TRIG : PRE;
                    end
                end
                PRE: begin
                    if (in_valid) begin
                        take_word   = 1'b1;
                        pre_cnt_nxt = pre_cnt_inc;
                        if (pre_cnt_inc == pre_words_q) begin
                            state_nxt = WAIT_TRIG;
                        end
                    end
                end
                WAIT_TRIG: begin
                    if (in_valid) begin
                        take_word = 1'b1;
                        if (in_triggered) begin
                            trig_addr_nxt   = ptr;
                            trig_sample_nxt = in_trig_sample;
                            post_cnt_nxt    = post_words_q;
                            state_nxt       = (post_words_q == '0) ? DONE : POST;
                        end
                    end
                end
                POST: begin
                    if (in_valid) begin
                        take_word    = 1'b1;
                        post_cnt_nxt = post_cnt - ADDR_W'(1);
                        if (post_cnt == ADDR_W'(1)) begin
                            state_nxt = DONE;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end

        // The pointer wraps silently, overwriting the oldest words.
        if (take_word) begin
            wr_en_nxt   = 1'b1;
            wr_addr_nxt = ptr;
            wr_data_nxt = in_data;
            ptr_nxt     = ptr + ADDR_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values computed above.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            ptr          <= '0;
            pre_cnt      <= '0;
            post_cnt     <= '0;
            pre_words_q  <= '0;
            post_words_q <= '0;
            trig_addr    <= '0;
            trig_sample  <= '0;
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
        end else begin
            state        <= state_nxt;
            ptr          <= ptr_nxt;
            pre_cnt      <= pre_cnt_nxt;
            post_cnt     <= post_cnt_nxt;
            pre_words_q  <= pre_words_nxt;
            post_words_q <= post_words_nxt;
            trig_addr    <= trig_addr_nxt;
            trig_sample  <= trig_sample_nxt;
            wr_en        <= wr_en_nxt;
            wr_addr      <= wr_addr_nxt;
            wr_data      <= wr_data_nxt;
        end
    end

    // Status follows the registered state, so it lines up with the registered write.
    assign busy = is_capturing(state);
    assign done = (state == DONE);

endmodule

// File: tb/tb_capture_sequencer.sv
// Self-checking bench for capture_sequencer: two instances (ADDR_W=12 and 3)
// share stimulus and are compared against a word-list reference model.
module tb_capture_sequencer;
    import capture_pkg::*;

    localparam int AW  = 12;
    localparam int AW3 = 3;
    localparam int MAXN = 64;

    logic clk = 1'b0;
    logic rst;
    logic arm, abort, in_valid, in_triggered;
    logic [255:0] in_data;
    logic [7:0]   in_trig_sample;
    logic [AW-1:0] pre_words, post_words;

    logic          wr_en_a, busy_a, done_a;
    logic [AW-1:0] wr_addr_a, trig_addr_a;
    logic [255:0]  wr_data_a;
    logic [7:0]    trig_sample_a;

    logic           wr_en_b, busy_b, done_b;
    logic [AW3-1:0] wr_addr_b, trig_addr_b;
    logic [255:0]   wr_data_b;
    logic [7:0]     trig_sample_b;

    capture_sequencer #(.ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .arm(arm), .abort(abort),
        .pre_words(pre_words), .post_words(post_words),
        .in_valid(in_valid), .in_data(in_data), .in_triggered(in_triggered),
        .in_trig_sample(in_trig_sample),
        .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
        .busy(busy_a), .done(done_a), .trig_addr(trig_addr_a), .trig_sample(trig_sample_a)
    );

    capture_sequencer #(.ADDR_W(AW3)) dut_small (
        .clk(clk), .rst(rst), .arm(arm), .abort(abort),
        .pre_words(pre_words[AW3-1:0]), .post_words(post_words[AW3-1:0]),
        .in_valid(in_valid), .in_data(in_data), .in_triggered(in_triggered),
        .in_trig_sample(in_trig_sample),
        .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
        .busy(busy_b), .done(done_b), .trig_addr(trig_addr_b), .trig_sample(trig_sample_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int           addr;
        logic [255:0] data;
        int           cyc;
    } wr_t;

    // Monitor: every observed write and every rising edge of done, per instance.
    wr_t got_a[$];
    wr_t got_b[$];
    int  rise_a[$];
    int  rise_b[$];
    logic prev_done_a = 1'b0;
    logic prev_done_b = 1'b0;

    always @(negedge clk) begin
        if (wr_en_a === 1'b1) got_a.push_back('{int'(wr_addr_a), wr_data_a, cyc});
        if (wr_en_b === 1'b1) got_b.push_back('{int'(wr_addr_b), wr_data_b, cyc});
        if (done_a === 1'b1 && prev_done_a !== 1'b1) rise_a.push_back(cyc);
        if (done_b === 1'b1 && prev_done_b !== 1'b1) rise_b.push_back(cyc);
        prev_done_a = done_a;
        prev_done_b = done_b;
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Stimulus for one capture, one entry per cycle after the arm cycle.
    bit           s_valid [MAXN];
    bit           s_trig  [MAXN];
    bit           s_abort [MAXN];
    bit           s_arm   [MAXN];
    logic [255:0] s_data  [MAXN];
    logic [7:0]   s_ts    [MAXN];
    int           s_cyc   [MAXN];

    // Reference model results.
    wr_t  m_q[$];
    int   m_trig_addr;
    int   m_trig_sample;
    bit   m_done, m_busy, m_complete;
    bit   last_busy;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stim();
        for (int i = 0; i < MAXN; i++) begin
            s_valid[i] = 1'b0; s_trig[i] = 1'b0; s_abort[i] = 1'b0; s_arm[i] = 1'b0;
            s_data[i]  = {8{$urandom}};
            s_ts[i]    = 8'($urandom);
        end
    endtask

    // Word-list model: the accepted words are the valid words seen before any
    // abort; the first pre of them fill the buffer, the first later flagged
    // word is the trigger, and post more words follow it.
    task automatic model(input int pre, input int post, input int aw, input int n);
        int vlist[$];
        int abort_at, trig_j, last, len;
        m_q.delete();
        abort_at = n;
        for (int i = 0; i < n; i++) if (s_abort[i]) begin abort_at = i; break; end
        for (int i = 0; i < abort_at; i++) if (s_valid[i]) vlist.push_back(i);
        len = vlist.size();
        trig_j = -1;
        for (int j = pre; j < len; j++) if (s_trig[vlist[j]]) begin trig_j = j; break; end
        m_complete = (trig_j >= 0) && (trig_j + post < len);
        if (trig_j < 0)      last = len - 1;
        else if (m_complete) last = trig_j + post;
        else                 last = len - 1;
        for (int k = 0; k <= last; k++)
            m_q.push_back('{k % (1 << aw), s_data[vlist[k]], s_cyc[vlist[k]] + 1});
        m_trig_addr   = (trig_j >= 0) ? trig_j % (1 << aw) : 0;
        m_trig_sample = (trig_j >= 0) ? int'(s_ts[vlist[trig_j]]) : 0;
        m_done = m_complete && (abort_at == n);
        m_busy = !m_complete && (abort_at == n);
    endtask

    // Arms both instances, plays s_* for n cycles and compares every write and
    // the final status of each instance against the model.
    task automatic run_capture(input string name, input int pre, input int post, input int n);
        int base_a, base_b, rb_a, rb_b;
        wr_t got[$];
        int  rises[$];
        int  act_busy, act_done, act_taddr, act_tsamp, exp_rise, act_rise;
        base_a = got_a.size(); base_b = got_b.size();
        rb_a = rise_a.size();  rb_b = rise_b.size();

        pre_words = AW'(pre); post_words = AW'(post);
        arm = 1'b1; abort = 1'b0;
        in_valid = 1'b1; in_triggered = 1'b1; in_data = {8{$urandom}}; in_trig_sample = 8'hA5;
        step();
        arm = 1'b0;
        for (int i = 0; i < n; i++) begin
            pre_words      = AW'($urandom_range(0, 7));
            post_words     = AW'($urandom_range(0, 7));
            arm            = s_arm[i];
            abort          = s_abort[i];
            in_valid       = s_valid[i];
            in_triggered   = s_trig[i];
            in_data        = s_data[i];
            in_trig_sample = s_ts[i];
            s_cyc[i]       = cyc;
            step();
            if (s_abort[i]) begin
                n_checks++;
                if ({wr_en_a, busy_a, done_a} !== 3'b000) begin
                    n_fail++;
                    $display("FAIL %s abort_next_cycle: wr_en/busy/done=%b required 000", name, {wr_en_a, busy_a, done_a});
                end
            end
        end
        arm = 1'b0; abort = 1'b0; in_valid = 1'b0; in_triggered = 1'b0;
        step();
        step();

        for (int w = 0; w < 2; w++) begin
            got.delete(); rises.delete();
            model(pre, post, (w == 0) ? AW : AW3, n);
            if (w == 0) begin
                for (int k = base_a; k < got_a.size(); k++) got.push_back(got_a[k]);
                for (int k = rb_a; k < rise_a.size(); k++) rises.push_back(rise_a[k]);
                act_busy = int'(busy_a); act_done = int'(done_a);
                act_taddr = int'(trig_addr_a); act_tsamp = int'(trig_sample_a);
                last_busy = m_busy;
            end else begin
                for (int k = base_b; k < got_b.size(); k++) got.push_back(got_b[k]);
                for (int k = rb_b; k < rise_b.size(); k++) rises.push_back(rise_b[k]);
                act_busy = int'(busy_b); act_done = int'(done_b);
                act_taddr = int'(trig_addr_b); act_tsamp = int'(trig_sample_b);
            end

            n_checks++;
            if (got.size() != m_q.size()) begin
                n_fail++;
                $display("FAIL %s[%0d] write_count: got %0d required %0d", name, w, got.size(), m_q.size());
            end
            for (int k = 0; k < got.size() && k < m_q.size(); k++) begin
                n_checks++;
                if (got[k].addr != m_q[k].addr || got[k].data !== m_q[k].data || got[k].cyc != m_q[k].cyc) begin
                    n_fail++;
                    $display("FAIL %s[%0d] write%0d: addr %0d cyc %0d data %h required addr %0d cyc %0d data %h",
                             name, w, k, got[k].addr, got[k].cyc, got[k].data[31:0],
                             m_q[k].addr, m_q[k].cyc, m_q[k].data[31:0]);
                end
            end
            n_checks++;
            if (act_busy != int'(m_busy) || act_done != int'(m_done)) begin
                n_fail++;
                $display("FAIL %s[%0d] status: busy %0d done %0d required busy %0d done %0d",
                         name, w, act_busy, act_done, m_busy, m_done);
            end
            n_checks++;
            if (act_taddr != m_trig_addr || act_tsamp != m_trig_sample) begin
                n_fail++;
                $display("FAIL %s[%0d] trigger: addr %0d sample %0d required addr %0d sample %0d",
                         name, w, act_taddr, act_tsamp, m_trig_addr, m_trig_sample);
            end
            exp_rise = m_complete ? m_q[m_q.size() - 1].cyc : -1;
            act_rise = (rises.size() > 0) ? rises[0] : -1;
            n_checks++;
            if (act_rise != exp_rise || rises.size() > 1) begin
                n_fail++;
                $display("FAIL %s[%0d] done_rise_cycle: got %0d required %0d", name, w, act_rise, exp_rise);
            end
        end

        // Leave both instances idle if the capture never finished.
        if (last_busy) begin
            abort = 1'b1;
            step();
            abort = 1'b0;
            step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; arm = 1'b0; abort = 1'b0; in_valid = 1'b0; in_triggered = 1'b0;
        in_data = '0; in_trig_sample = '0; pre_words = '0; post_words = '0;
        #12;
        n_checks++;
        if ({wr_en_a, busy_a, done_a, wr_addr_a, trig_addr_a, trig_sample_a} !== '0 || wr_data_a !== '0 ||
            {wr_en_b, busy_b, done_b, wr_addr_b, trig_addr_b, trig_sample_b} !== '0 || wr_data_b !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: busy %b done %b wr_en %b required all zero", busy_a, done_a, wr_en_a);
        end
        @(negedge clk);
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        clear_stim();
        for (int i = 0; i < 12; i++) s_valid[i] = 1'b1;
        s_trig[5] = 1'b1;
        run_capture("basic_pre4_post3", 4, 3, 12);
    endtask

    task automatic test_pre_trigger_ignored();
        clear_stim();
        for (int i = 0; i < 12; i++) s_valid[i] = 1'b1;
        s_trig[1] = 1'b1;
        s_trig[6] = 1'b1;
        run_capture("trigger_in_pre", 4, 2, 12);
    endtask

    task automatic test_wrap();
        clear_stim();
        for (int i = 0; i < 14; i++) s_valid[i] = 1'b1;
        s_trig[10] = 1'b1;
        s_trig[12] = 1'b1;
        run_capture("wrap_post0", 2, 0, 14);
        n_checks++;
        if (trig_addr_b !== 3'd2) begin
            n_fail++;
            $display("FAIL wrap_trig_addr_small: got %0d required 2", trig_addr_b);
        end
    endtask

    task automatic test_abort();
        clear_stim();
        for (int i = 0; i < 10; i++) s_valid[i] = 1'b1;
        s_trig[2]  = 1'b1;
        s_abort[4] = 1'b1;
        run_capture("abort_in_post", 2, 5, 10);
        clear_stim();
        for (int i = 0; i < 6; i++) s_valid[i] = 1'b1;
        s_trig[1] = 1'b1;
        run_capture("rearm_after_abort", 1, 2, 6);
    endtask

    task automatic test_sparse_and_arm_abort();
        int base;
        clear_stim();
        for (int i = 0; i < 16; i++) begin
            s_valid[i] = (i % 4 == 0);
            s_trig[i]  = 1'b1;
        end
        run_capture("sparse_pre0_post0", 0, 0, 16);
        n_checks++;
        if (done_a !== 1'b1) begin
            n_fail++;
            $display("FAIL sparse_done_held: got %b required 1", done_a);
        end
        base = got_a.size();
        arm = 1'b1; abort = 1'b1; in_valid = 1'b1;
        step();
        arm = 1'b0; abort = 1'b0;
        n_checks++;
        if ({busy_a, done_a, wr_en_a} !== 3'b000) begin
            n_fail++;
            $display("FAIL arm_abort_together: busy/done/wr_en=%b required 000", {busy_a, done_a, wr_en_a});
        end
        step(); step();
        in_valid = 1'b0;
        step(); step();
        n_checks++;
        if (got_a.size() != base) begin
            n_fail++;
            $display("FAIL idle_no_writes: got %0d writes required 0", got_a.size() - base);
        end
    endtask

    task automatic test_arm_ignored();
        clear_stim();
        for (int i = 0; i < 14; i++) s_valid[i] = 1'b1;
        s_arm[1]  = 1'b1;
        s_arm[4]  = 1'b1;
        s_trig[6] = 1'b1;
        s_arm[8]  = 1'b1;
        run_capture("arm_while_busy", 3, 3, 14);
    endtask

    task automatic test_random();
        for (int r = 0; r < 8; r++) begin
            clear_stim();
            for (int i = 0; i < 30; i++) begin
                s_valid[i] = ($urandom_range(0, 99) < 70);
                s_trig[i]  = ($urandom_range(0, 99) < 20);
            end
            if (r == 5) s_abort[$urandom_range(3, 20)] = 1'b1;
            run_capture($sformatf("random%0d", r), $urandom_range(0, 7), $urandom_range(0, 7), 30);
        end
    endtask

    task automatic test_rst_mid();
        int base;
        pre_words = '0; post_words = AW'(3);
        arm = 1'b1;
        step();
        arm = 1'b0;
        in_valid = 1'b1; in_triggered = 1'b0; in_data = {8{$urandom}} | 256'h1;
        step(); step(); step();
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({wr_en_a, busy_a, done_a, wr_addr_a, trig_addr_a, trig_sample_a} !== '0 || wr_data_a !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_outputs: busy %b wr_addr %0d wr_data %h required all zero",
                     busy_a, wr_addr_a, wr_data_a[31:0]);
        end
        @(negedge clk);
        rst = 1'b0;
        step();
        base = got_a.size();
        n_checks++;
        if ({busy_a, done_b, busy_b, done_a} !== 4'b0000) begin
            n_fail++;
            $display("FAIL rst_mid_idle: busy %b done %b required 0 0", busy_a, done_a);
        end
        in_valid = 1'b1; in_triggered = 1'b1;
        step(); step();
        in_valid = 1'b0;
        step(); step();
        n_checks++;
        if (got_a.size() != base) begin
            n_fail++;
            $display("FAIL rst_mid_no_writes: got %0d writes required 0", got_a.size() - base);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_pre_trigger_ignored();
        test_wrap();
        test_abort();
        test_sparse_and_arm_abort();
        test_arm_ignored();
        test_random();
        test_rst_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
